serial_shifter: RTL
===================

SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data width (power of two, minimum 8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-004 SHALL have port start, input, 1, requests a new shift operation.
REQ-005 SHALL have port op, input, 2, shift type: 00 SLL, 01 SRL, 11 SRA, 10 reserved (treated as SRL).
REQ-006 SHALL have port data_in, input, XLEN, the operand.
REQ-007 SHALL have port shamt, input, log2(XLEN), the shift amount.
REQ-008 SHALL have port busy, output, 1, high in SHIFT and DONE.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, XLEN, the shifted value.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE; all outputs registered or decoded from state only.
REQ-012 SHALL sample start, op, data_in and shamt only in IDLE; at edge N with start=1, it loads result<=data_in and count<=shamt, latches op, and enters SHIFT.
REQ-013 SHALL, in SHIFT, per edge: if count==0, go to DONE; else shift result by one step and decrement count by the step size.
REQ-014 SHALL shift by one bit per step: SLL fills 0 at LSB, SRL fills 0 at MSB, SRA replicates result[XLEN-1].
REQ-015 SHALL assert done for exactly the one cycle after edge N+k+1, where k is the number of shift steps, then return to IDLE at edge N+k+2.
REQ-016 SHALL, for shamt=0, keep result=data_in and assert done after edge N+1.
REQ-017 SHALL ignore start while busy=1; the in-flight operation is unaffected.
REQ-018 SHALL hold result stable from DONE until the next accepted start.
REQ-019 SHALL leave result holding the partial value during SHIFT; its contents there are not defined as valid.

Reset
REQ-020 SHALL, on rst_n=0, immediately force state=IDLE, busy=0, done=0, result=0 and count=0, including mid-operation.
REQ-021 SHALL accept a start on the first rising edge after rst_n deasserts.

Configuration
REQ-022 SHALL, when macro SERIAL_SHIFTER_BY4_EN is defined, shift by 4 bits per step when count>=4 and by 1 bit otherwise, so k = shamt/4 + shamt%4.
REQ-023 SHALL, without SERIAL_SHIFTER_BY4_EN, use k = shamt, with no 4-bit datapath logic present.
REQ-024 SHALL keep the interface, the FSM and the done timing relative to k identical in both builds.

Structure
REQ-025 SHALL take the op encodings (SLL, SRL, SRA) and the FSM state encoding from the shared CPU package.
REQ-026 SHALL use one sub-module, shift_step: a combinational one-step shifter (1 bit, or 4 bits under the macro) selected by op; the FSM and registers stay in serial_shifter.
REQ-027 SHALL be synthesizable to the project cell set plus D flip-flops, with no behavioural multiply or variable shift operators.

Verification (XLEN=32)
REQ-028 SHALL cover: SRA, data_in=0x80000000, shamt=4 -> result=0xF8000000, done after edge N+5, or after N+2 with the macro.
REQ-029 SHALL cover: SLL, data_in=0x00000001, shamt=31 -> result=0x80000000, done after edge N+32, or after N+11 with the macro.
REQ-030 SHALL cover: SRL, data_in=0xDEADBEEF, shamt=0 -> result=0xDEADBEEF, done after edge N+1, busy high for 2 cycles.
REQ-031 SHALL cover: start pulsed with data_in=0x12345678 during an SRL of 0xFFFF0000 by 8 -> result=0x00FFFF00, and the second start is dropped.
REQ-032 SHALL cover: rst_n=0 mid-SHIFT -> busy=0, done=0, result=0 immediately; a new SLL of 0x3 by 1 afterwards gives result=0x6.
REQ-033 SHALL cover: random op, data_in and shamt (10k operations) against a reference model, with done pulse width always 1.

Source files
------------

// File: rtl/serial_shifter_pkg.sv
// Shared definitions for the serial shifter: op encodings, FSM state encoding and step helpers.
// Optional feature macro: SERIAL_SHIFTER_BY4_EN (4-bit shift steps).
package serial_shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_RSVD = 2'b10,
        OP_SRA  = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

    localparam int unsigned BIG_STEP = 4;

    // Bit shifted in at the MSB for right shifts; only SRA propagates the sign.
    function automatic logic fill_bit(input shift_op_e op, input logic msb);
        return (op == OP_SRA) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/serial_shifter_shift_step.sv
// Combinational single-step shifter: one bit per step, or four bits when by4_i is set.
// Optional feature macro: SERIAL_SHIFTER_BY4_EN adds the 4-bit path.
module shift_step
    import serial_shifter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  shift_op_e         op_i,
`ifdef SERIAL_SHIFTER_BY4_EN
    input  logic              by4_i,
`endif
    input  logic [XLEN-1:0]   data_i,
    output logic [XLEN-1:0]   data_o
);

    logic            fill;
    logic [XLEN-1:0] one_step;

    assign fill = fill_bit(op_i, data_i[XLEN-1]);

    // NOTE: every output of a combinational block gets a value on every path; a
    // missing default makes synthesis infer a latch to hold the old value.
    always_comb begin
        one_step = {fill, data_i[XLEN-1:1]};
        if (op_i == OP_SLL) begin
            one_step = {data_i[XLEN-2:0], 1'b0};
        end
    end

`ifdef SERIAL_SHIFTER_BY4_EN
    logic [XLEN-1:0] four_step;

    always_comb begin
        four_step = {{4{fill}}, data_i[XLEN-1:4]};
        if (op_i == OP_SLL) begin
            four_step = {data_i[XLEN-5:0], 4'b0000};
        end
    end

    assign data_o = by4_i ? four_step : one_step;
`else
    assign data_o = one_step;
`endif

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shifter: IDLE -> SHIFT (one step per clock) -> DONE (one-cycle done pulse).
// Optional feature macro: SERIAL_SHIFTER_BY4_EN shifts four bits per step while count >= 4.
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] data_in,
    input  logic [SW-1:0]   shamt,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    shift_state_e    state_q;
    shift_op_e       op_q;
    logic [SW-1:0]   count_q;
    logic [SW-1:0]   count_d;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] result_d;
    logic            busy_q;
    logic            done_q;

`ifdef SERIAL_SHIFTER_BY4_EN
    logic by4;

    assign by4     = (count_q >= SW'(BIG_STEP));
    assign count_d = by4 ? (count_q - SW'(BIG_STEP)) : (count_q - SW'(1));

    shift_step #(
        .XLEN (XLEN)
    ) u_step (
        .op_i   (op_q),
        .by4_i  (by4),
        .data_i (result_q),
        .data_o (result_d)
    );
`else
    assign count_d = count_q - SW'(1);

    shift_step #(
        .XLEN (XLEN)
    ) u_step (
        .op_i   (op_q),
        .data_i (result_q),
        .data_o (result_d)
    );
`endif

    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_SLL;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        result_q <= data_in;
                        count_q  <= shamt;
                        op_q     <= shift_op_e'(op);
                        state_q  <= ST_SHIFT;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (count_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        result_q <= result_d;
                        count_q  <= count_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
